// File: rtl/mdu.sv
// MIPS multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO result registers.
// The 64-bit result is computed when the op is accepted and held in a shadow register until commit.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        res_q, res_d;
    logic               skip_q, skip_d;

    // Full 64-bit product; operands widened so the signed and unsigned cases share one multiplier.
    function automatic logic [63:0] mul_full(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic signed [65:0] xe;
        logic signed [65:0] ye;
        logic signed [65:0] p;
        xe = {{34{sgn & x[31]}}, x};
        ye = {{34{sgn & y[31]}}, y};
        p  = xe * ye;
        return p[63:0];
    endfunction

    // Returns {remainder, quotient}. Signed division goes through magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    function automatic logic [63:0] div_full(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic        neg_x;
        logic        neg_y;
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        neg_x = sgn & x[31];
        neg_y = sgn & y[31];
        mx    = neg_x ? -x : x;
        my    = neg_y ? -y : y;
        if (my == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mx / my;
            r = mx % my;
        end
        if (neg_x ^ neg_y) q = -q;
        if (neg_x)         r = -r;
        return {r, q};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            res_d   = mul_full(a, b, ~op[0]);
                            skip_d  = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        3'd2, 3'd3: begin
                            res_d   = div_full(a, b, ~op[0]);
                            skip_d  = (b == 32'd0);
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Start strobes are ignored here; the hazard unit stalls upstream.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!skip_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            skip_q  <= skip_d;
        end
    end

    // Shadow result is pure data; returning to IDLE on reset is enough to discard it.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
